fixed_point_iterative_divider: RTL and testbench
================================================

# fixed_point_iterative_divider

Sequential fixed-point divider: inverse operation of the combinational fixed-point multiplier, sharing its `n`/`d`/`sign` Q-format conventions. Computes `c = (a << d) / b` with a radix-2 restoring algorithm, one quotient bit per cycle, behind val/rdy handshakes on both sides. It sits in the same arithmetic library as the multiplier and serves datapaths that need division too rarely to justify a combinational array.

## Interface
- `n`, 32, total bit width of operands and result
- `d`, 16, fractional bits (0 ≤ d < n)
- `sign`, 1, 1 = two's-complement operands/result, 0 = unsigned

- `clk` input 1 clock, all state updates on rising edge
- `reset` input 1 synchronous, active-high
- `recv_val` input 1 operands valid
- `recv_rdy` output 1 divider can accept operands
- `a` input n dividend (Q(n-d).d)
- `b` input n divisor (Q(n-d).d)
- `send_val` output 1 result valid
- `send_rdy` input 1 consumer accepts result
- `c` output n quotient (Q(n-d).d)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `recv_rdy`=1. On `recv_val && recv_rdy`, latch operands and go to CALC with iteration counter = n+d.
- Signed mode: latch magnitudes |a| and |b| as n-bit unsigned (|−2^(n−1)| = 2^(n−1)); record `neg = a[n-1] ^ b[n-1]`. Unsigned mode: latch as-is, `neg`=0.
- CALC: dividend = {|a|, d zeros} (n+d bits), shifted MSB-first into an (n+1)-bit partial remainder. Each cycle: shift in next dividend bit; if remainder ≥ |b|, subtract and set quotient bit 1, else 0. Decrement counter; at 0 go to DONE.
- Result: low n bits of the (n+d)-bit quotient (upper bits discarded, wrap on overflow, same truncation rule as the multiplier). If `neg`, result = two's-complement negation. Rounding: truncation toward zero.
- Divide by zero (`b`=0, detected at accept): normal latency; result forced to all ones (unsigned), 0x7FF…F for a ≥ 0, 0x800…0 for a < 0 (signed).
- DONE: `send_val`=1, `c` held stable. On `send_rdy`, go to IDLE.
- `recv_rdy`=0 in CALC and DONE; no accept in the same cycle a result leaves.

## Timing
- Reset: state IDLE, `send_val`=0, `c`=0, counter 0; `recv_rdy`=0 while `reset` is high, 1 the first cycle after.
- Reset in CALC or DONE aborts: in-flight result discarded, never presented.
- Latency: operands accepted on edge E → `send_val` high after edge E+n+d (n+d CALC cycles, 48 for defaults). Throughput: one result per n+d+2 cycles minimum.
- `a`/`b` ignored outside the accept cycle; `c` undefined-stable only while `send_val`=0, exactly the quotient while `send_val`=1.
- `send_rdy` held low: stays in DONE indefinitely, `c` and `send_val` unchanged.

## Structure
- Package `fixed_point_divider_pkg`: state enum (IDLE, CALC, DONE), and a function for the divide-by-zero saturation value parameterised on n and sign.
- One sub-module is natural: `fixed_point_iterative_divider_step`, combinational single restoring step (remainder, divisor in → next remainder, quotient bit out). Top level holds FSM, counter, operand/quotient registers, sign fix-up.

## Test plan
- n=32,d=16,sign=1: a=0x00030000 (3.0), b=0x00020000 (2.0) → `c`=0x00018000 after exactly 48 CALC cycles; `recv_rdy` low throughout.
- Signed truncation: a=0xFFFF0000 (−1.0), b=0x00030000 → `c`=0xFFFFAAAB; a=0x00010000, b=0x00030000 → 0x00005555.
- Divide by zero: a=0x00010000, b=0 → 0x7FFFFFFF; a=0xFFFF0000, b=0 → 0x80000000; same latency.
- Backpressure: hold `send_rdy`=0 for 10 cycles in DONE → `c` stable, `send_val`=1, `recv_rdy`=0; raise `send_rdy` → IDLE next cycle, back-to-back transaction accepted correctly.
- Unsigned n=8,d=4,sign=0: a=0xF0 (15.0), b=0x20 (2.0) → `c`=0x78; a=0xFF, b=0x01 → wrapped low 8 bits 0xF0.
- Reset asserted mid-CALC → `send_val` stays 0, `recv_rdy` 1 cycle after release, next division correct; random signed vectors vs. golden truncate-toward-zero model.

Source files
------------

// File: rtl/fixed_point_divider_pkg.sv
// fixed_point_divider_pkg
//   Shared definitions for the iterative fixed-point divider:
//   - div_state_t : controller states (IDLE, CALC, DONE)
//   - dz_value()  : saturation value returned for a zero divisor,
//                   parameterised on operand width and signedness
package fixed_point_divider_pkg;

   // Widest operand the saturation helper can describe.
   localparam int unsigned MAX_N = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Divide-by-zero result, right-aligned in a MAX_N-bit word.
   // Unsigned: all ones. Signed: largest positive value for a >= 0,
   // most negative value for a < 0.
   function automatic logic [MAX_N-1:0] dz_value(input int unsigned width,
                                                 input bit          is_signed,
                                                 input bit          a_negative);
      logic [MAX_N-1:0] ones;
      ones = {MAX_N{1'b1}} >> (MAX_N - width);
      if (!is_signed)
         return ones;
      if (a_negative)
         return {{(MAX_N-1){1'b0}}, 1'b1} << (width - 1);
      return ones >> 1;
   endfunction

endpackage

// File: rtl/fixed_point_iterative_divider_step.sv
// fixed_point_iterative_divider_step
//   One combinational restoring-division step.
//   Ports:
//     rem_in  [W-1:0] : current partial remainder (always < divisor)
//     bit_in          : next dividend bit, shifted in at the LSB
//     divisor [W-1:0] : divisor magnitude
//     rem_out [W-1:0] : remainder after the trial subtraction
//     q_bit           : quotient bit produced by this step
module fixed_point_iterative_divider_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   // The shifted remainder needs one extra bit; after a successful
   // subtraction it is again below the divisor and fits in W bits.
   logic [W:0] partial;
   logic [W:0] diff;

   assign partial = {rem_in, bit_in};
   assign diff    = partial - {1'b0, divisor};
   assign q_bit   = (partial >= {1'b0, divisor});
   assign rem_out = q_bit ? W'(diff) : partial[W-1:0];

endmodule

// File: rtl/fixed_point_iterative_divider.sv
// fixed_point_iterative_divider
//   Sequential radix-2 restoring divider computing c = (a << d) / b,
//   one quotient bit per clock, with val/rdy handshakes on both sides.
//   Ports:
//     clk, reset         : clock, synchronous active-high reset
//     recv_val, recv_rdy : operand handshake (accept when both high)
//     a, b      [n-1:0]  : dividend / divisor, Q(n-d).d
//     send_val, send_rdy : result handshake (result leaves when both high)
//     c         [n-1:0]  : quotient, Q(n-d).d, truncated toward zero
module fixed_point_iterative_divider
   import fixed_point_divider_pkg::*;
#(
   parameter int n    = 32,
   parameter int d    = 16,
   parameter bit sign = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         recv_val,
   output logic         recv_rdy,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         send_val,
   input  logic         send_rdy,
   output logic [n-1:0] c
);

   localparam int CW = $clog2(n + d + 1);
   localparam logic [MAX_N-1:0] DZ_POS_FULL = dz_value(n, sign, 1'b0);
   localparam logic [MAX_N-1:0] DZ_NEG_FULL = dz_value(n, sign, 1'b1);

   div_state_t     state_reg, state_next;
   logic           accept;

   logic [CW-1:0]  cnt_reg;
   logic [n+d-1:0] dividend_reg;
   logic [n-1:0]   divisor_reg;
   logic [n-1:0]   rem_reg;
   logic [n-1:0]   quot_reg;
   logic           neg_reg;
   logic           dz_reg;
   logic           a_neg_reg;
   logic [n-1:0]   c_reg;

   logic [n-1:0]   a_mag;
   logic [n-1:0]   b_mag;
   logic [n-1:0]   rem_next;
   logic           q_bit;
   logic [n-1:0]   quot_next;
   logic [n-1:0]   result_next;

   // Operand magnitudes; -(-2^(n-1)) wraps to 2^(n-1), which is the
   // correct magnitude when read back as unsigned.
   generate
      if (sign) begin : g_signed
         assign a_mag = a[n-1] ? -a : a;
         assign b_mag = b[n-1] ? -b : b;
      end else begin : g_unsigned
         assign a_mag = a;
         assign b_mag = b;
      end
   endgenerate

   fixed_point_iterative_divider_step #(.W(n)) u_step (
      .rem_in  (rem_reg),
      .bit_in  (dividend_reg[n+d-1]),
      .divisor (divisor_reg),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   // Only the low n quotient bits are kept; higher bits wrap away.
   assign quot_next = n'({quot_reg, q_bit});

   always_comb begin
      result_next = neg_reg ? -quot_next : quot_next;
      if (dz_reg)
         result_next = a_neg_reg ? DZ_NEG_FULL[n-1:0] : DZ_POS_FULL[n-1:0];
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      recv_rdy   = 1'b0;
      send_val   = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            recv_rdy = !reset;
            if (recv_val && !reset) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            if (cnt_reg == CW'(1))
               state_next = DONE;
         end
         DONE: begin
            send_val = 1'b1;
            if (send_rdy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg      <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         rem_reg      <= '0;
         quot_reg     <= '0;
         neg_reg      <= 1'b0;
         dz_reg       <= 1'b0;
         a_neg_reg    <= 1'b0;
         c_reg        <= '0;
      end else if (accept) begin
         cnt_reg      <= CW'(n + d);
         dividend_reg <= (n+d)'(a_mag) << d;
         divisor_reg  <= b_mag;
         rem_reg      <= '0;
         quot_reg     <= '0;
         neg_reg      <= sign & (a[n-1] ^ b[n-1]);
         dz_reg       <= (b == '0);
         a_neg_reg    <= sign & a[n-1];
      end else if (state_reg == CALC) begin
         cnt_reg      <= cnt_reg - CW'(1);
         dividend_reg <= dividend_reg << 1;
         rem_reg      <= rem_next;
         quot_reg     <= quot_next;
         // Final step: capture the sign-corrected result for DONE.
         if (cnt_reg == CW'(1))
            c_reg <= result_next;
      end
   end

   assign c = c_reg;

endmodule

// File: tb/tb_fixed_point_iterative_divider.sv
// tb_fixed_point_iterative_divider
//   Directed bench for the iterative divider: one signed Q16.16
//   instance (n=32,d=16) and one unsigned Q4.4 instance (n=8,d=4).
module tb_fixed_point_iterative_divider;

   logic clk = 1'b0;
   logic reset;

   // signed 32/16 instance
   logic        s_recv_val, s_recv_rdy, s_send_val, s_send_rdy;
   logic [31:0] s_a, s_b, s_c;
   // unsigned 8/4 instance
   logic        u_recv_val, u_recv_rdy, u_send_val, u_send_rdy;
   logic [7:0]  u_a, u_b, u_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fixed_point_iterative_divider #(.n(32), .d(16), .sign(1'b1)) dut_s (
      .clk      (clk),
      .reset    (reset),
      .recv_val (s_recv_val),
      .recv_rdy (s_recv_rdy),
      .a        (s_a),
      .b        (s_b),
      .send_val (s_send_val),
      .send_rdy (s_send_rdy),
      .c        (s_c)
   );

   fixed_point_iterative_divider #(.n(8), .d(4), .sign(1'b0)) dut_u (
      .clk      (clk),
      .reset    (reset),
      .recv_val (u_recv_val),
      .recv_rdy (u_recv_rdy),
      .a        (u_a),
      .b        (u_b),
      .send_val (u_send_val),
      .send_rdy (u_send_rdy),
      .c        (u_c)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Present operands at a negedge, let the next posedge accept them,
   // then scramble a/b to show they are ignored afterwards.
   task automatic start_op(input bit u8, input logic [31:0] av, input logic [31:0] bv,
                           input string tag);
      if (u8) begin
         check({tag, " recv_rdy before accept"}, {31'd0, u_recv_rdy}, 32'd1);
         u_a = av[7:0]; u_b = bv[7:0]; u_recv_val = 1'b1;
         @(negedge clk);
         u_recv_val = 1'b0; u_a = 8'hA5; u_b = 8'h5A;
      end else begin
         check({tag, " recv_rdy before accept"}, {31'd0, s_recv_rdy}, 32'd1);
         s_a = av; s_b = bv; s_recv_val = 1'b1;
         @(negedge clk);
         s_recv_val = 1'b0; s_a = 32'hDEADBEEF; s_b = 32'h12345678;
      end
   endtask

   // Count clock edges since the accept edge until send_val rises.
   task automatic wait_result(input bit u8, output int lat, output bit rdy_seen);
      lat = 0;
      rdy_seen = 1'b0;
      while (!(u8 ? u_send_val : s_send_val) && lat < 200) begin
         if (u8 ? u_recv_rdy : s_recv_rdy) rdy_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op(input bit u8, input string tag);
      if (u8) u_send_rdy = 1'b1; else s_send_rdy = 1'b1;
      @(negedge clk);
      u_send_rdy = 1'b0;
      s_send_rdy = 1'b0;
      check({tag, " send_val after leave"}, {31'd0, u8 ? u_send_val : s_send_val}, 32'd0);
      check({tag, " recv_rdy after leave"}, {31'd0, u8 ? u_recv_rdy : s_recv_rdy}, 32'd1);
   endtask

   task automatic div_op(input bit u8, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] expv, input string tag);
      int lat;
      bit rdy_seen;
      logic [31:0] cv;
      start_op(u8, av, bv, tag);
      wait_result(u8, lat, rdy_seen);
      cv = u8 ? {24'd0, u_c} : s_c;
      check({tag, " latency"}, 32'(lat), u8 ? 32'd12 : 32'd48);
      check({tag, " recv_rdy low in CALC"}, {31'd0, rdy_seen}, 32'd0);
      check({tag, " c"}, cv, expv);
      $display("[TB] %s a=0x%08h b=0x%08h c=0x%08h latency=%0d", tag, av, bv, cv, lat);
      finish_op(u8, tag);
   endtask

   initial begin
      int          lat;
      bit          rdy_seen;
      bit          stable;
      bit          leaked;
      logic [31:0] held;

      reset = 1'b1;
      s_recv_val = 1'b0; s_send_rdy = 1'b0; s_a = '0; s_b = '0;
      u_recv_val = 1'b0; u_send_rdy = 1'b0; u_a = '0; u_b = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset send_val", {31'd0, s_send_val}, 32'd0);
      check("reset c", s_c, 32'd0);
      check("reset recv_rdy while high", {31'd0, s_recv_rdy}, 32'd0);
      check("reset u c", {24'd0, u_c}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("recv_rdy after reset", {31'd0, s_recv_rdy}, 32'd1);

      // Signed Q16.16
      div_op(1'b0, 32'h00030000, 32'h00020000, 32'h00018000, "s 3/2");
      div_op(1'b0, 32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, "s -1/3");
      div_op(1'b0, 32'h00010000, 32'h00030000, 32'h00005555, "s 1/3");
      div_op(1'b0, 32'h00070000, 32'hFFFE0000, 32'hFFFC8000, "s 7/-2");
      div_op(1'b0, 32'hFFFF8000, 32'hFFFF0000, 32'h00008000, "s -0.5/-1");
      div_op(1'b0, 32'h80000000, 32'h00010000, 32'h80000000, "s min/1");
      div_op(1'b0, 32'h40000000, 32'h00008000, 32'h80000000, "s wrap");

      // Divide by zero
      div_op(1'b0, 32'h00010000, 32'h00000000, 32'h7FFFFFFF, "s 1/0");
      div_op(1'b0, 32'hFFFF0000, 32'h00000000, 32'h80000000, "s -1/0");

      // Backpressure: 2.5/2.0 held in DONE, then 9/4 back-to-back
      start_op(1'b0, 32'h00050000, 32'h00020000, "bp");
      wait_result(1'b0, lat, rdy_seen);
      check("bp latency", 32'(lat), 32'd48);
      held = s_c;
      check("bp c", held, 32'h00028000);
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (s_c !== held || s_send_val !== 1'b1 || s_recv_rdy !== 1'b0) stable = 1'b0;
      end
      check("bp hold stable", {31'd0, stable}, 32'd1);
      $display("[TB] bp held c=0x%08h for 10 cycles", held);
      s_send_rdy = 1'b1;
      s_recv_val = 1'b1; s_a = 32'h00090000; s_b = 32'h00040000;
      @(negedge clk);
      s_send_rdy = 1'b0;
      check("bp send_val after leave", {31'd0, s_send_val}, 32'd0);
      check("bp no accept on leave", {31'd0, s_recv_rdy}, 32'd1);
      @(negedge clk);
      s_recv_val = 1'b0; s_a = 32'hDEADBEEF; s_b = 32'h0;
      wait_result(1'b0, lat, rdy_seen);
      check("b2b latency", 32'(lat), 32'd48);
      check("b2b c", s_c, 32'h00024000);
      $display("[TB] b2b a=0x00090000 b=0x00040000 c=0x%08h latency=%0d", s_c, lat);
      finish_op(1'b0, "b2b");

      // Unsigned Q4.4
      div_op(1'b1, 32'h000000F0, 32'h00000020, 32'h00000078, "u 15/2");
      div_op(1'b1, 32'h000000FF, 32'h00000001, 32'h000000F0, "u wrap");
      div_op(1'b1, 32'h00000010, 32'h00000000, 32'h000000FF, "u 1/0");

      // Reset mid-CALC aborts the operation
      start_op(1'b0, 32'h00030000, 32'h00020000, "rst");
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst recv_rdy during reset", {31'd0, s_recv_rdy}, 32'd0);
      check("rst send_val during reset", {31'd0, s_send_val}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst recv_rdy after release", {31'd0, s_recv_rdy}, 32'd1);
      leaked = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (s_send_val !== 1'b0) leaked = 1'b1;
      end
      check("rst no result presented", {31'd0, leaked}, 32'd0);
      $display("[TB] rst aborted mid-CALC, result suppressed=%0d", !leaked);
      div_op(1'b0, 32'hFFFD0000, 32'h00020000, 32'hFFFE8000, "s -3/2 after rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
